uart_tx_fifo: RTL and testbench

- Buffered, fully parametrised UART transmitter; next generation of the team's single-word UART TX.
- Adds a write FIFO with valid/ready handshake, configurable data width, even/odd/no parity, 1 or 2 stop bits, and back-to-back framing with no idle gap.
- Sits between the CPU's memory-mapped UART register block and the tx pin.
- Emits a per-frame completion pulse for interrupt and status logic.

---
 rtl/uart_tx_fifo.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small write FIFO with a valid/ready handshake
// feeds a framing FSM. The FSM supports 5..9 data bits, none/even/odd parity
// and 1 or 2 stop bits, and it sends frames back to back with no idle gap
// while words are queued.
module uart_tx_fifo #(
  parameter int ClockFreqHz = 10000000,
  parameter int BaudRate    = 9600,
  parameter int DataBits    = 8,
  parameter int ParityMode  = 0,
  parameter int StopBits    = 1,
  parameter int FifoDepth   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [DataBits-1:0]          wr_data,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  output logic                         tx,
  output logic                         busy,
  output logic                         frame_done,
  output logic [$clog2(FifoDepth):0]   fifo_count
);

  localparam int BitCycles  = ClockFreqHz / BaudRate;
  localparam int StopCycles = StopBits * BitCycles;
  localparam int CntMax     = (2 * BitCycles > DataBits) ? 2 * BitCycles : DataBits;
  localparam int CntW       = $clog2(CntMax + 1);
  localparam int PtrW       = $clog2(FifoDepth);
  localparam int CountW     = PtrW + 1;

  localparam logic [CntW-1:0]   BitEnd   = CntW'(BitCycles - 1);
  localparam logic [CntW-1:0]   StopEnd  = CntW'(StopCycles - 1);
  localparam logic [CntW-1:0]   BitLast  = CntW'(DataBits - 1);
  localparam logic [CountW-1:0] DepthVal = CountW'(FifoDepth);

  // Reject configurations the framing logic cannot honour.
  if (BitCycles < 2) begin : g_bad_baud
    $error("uart_tx_fifo: ClockFreqHz/BaudRate must be at least 2");
  end
  if (DataBits < 5 || DataBits > 9) begin : g_bad_data
    $error("uart_tx_fifo: DataBits must be within 5..9");
  end
  if (ParityMode < 0 || ParityMode > 2) begin : g_bad_parity
    $error("uart_tx_fifo: ParityMode must be 0, 1 or 2");
  end
  if (StopBits < 1 || StopBits > 2) begin : g_bad_stop
    $error("uart_tx_fifo: StopBits must be 1 or 2");
  end
  if (FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FifoDepth must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DataBits-1:0] d);
    return (ParityMode == 2) ? ~(^d) : (^d);
  endfunction

  logic [DataBits-1:0] mem_q [FifoDepth];
  logic [PtrW-1:0]     wptr_q, rptr_q;
  logic [CountW-1:0]   count_q, count_d;
  logic                wr_ready_q;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [CntW-1:0]     bit_q;
  logic [DataBits-1:0] shift_q;
  logic                par_q;
  logic                tx_q, busy_q, done_q;

  logic push, pop, bit_end, stop_end;

  assign bit_end  = (cnt_q == BitEnd);
  assign stop_end = (cnt_q == StopEnd);
  assign push     = wr_valid && wr_ready_q;
  // The FSM takes a word when idle, or at the last stop cycle to chain frames.
  assign pop      = (count_q != '0) &&
                    ((state_q == IDLE) || (state_q == STOP && stop_end));

  // Occupancy after this edge; push and pop together cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage is written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wr_data;
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      wr_ready_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q    <= count_d;
      wr_ready_q <= (count_d < DepthVal);
    end
  end

  // Shift register and parity are loaded with the head word on every pop.
  always_ff @(posedge clk) begin
    if (pop) begin
      shift_q <= mem_q[rptr_q];
      par_q   <= parity_bit(mem_q[rptr_q]);
    end else if (state_q == DATA && bit_end) begin
      shift_q <= shift_q >> 1;
    end
  end

  // Framing FSM with registered line, busy and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q  <= '0;
          bit_q  <= '0;
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (count_q != '0) begin
            state_q <= START;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_q == BitLast) begin
              if (ParityMode != 0) begin
                state_q <= PARITY;
                tx_q    <= par_q;
              end else begin
                state_q <= STOP;
                tx_q    <= 1'b1;
              end
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
            tx_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (stop_end) begin
            cnt_q  <= '0;
            done_q <= 1'b1;
            if (count_q != '0) begin
              state_q <= START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          bit_q   <= '0;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign wr_ready   = wr_ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1, 7E2, 7O2, all 10 clocks per
// bit). Every cycle's tx/busy/frame_done is logged; a frame-level model builds
// the expected waveform from the recorded push edges and compares it.
module tb_uart_tx_fifo;

  localparam int BC   = 10;
  localparam int MAXC = 8192;

  typedef struct {
    int         sel;
    int         p;
    logic [8:0] d;
  } push_t;

  logic       clk;
  logic       rst_n;
  logic [2:0] wr_valid_v;
  logic [8:0] wr_data_v [3];
  wire  [2:0] rdy_w, tx_w, busy_w, done_w;
  wire  [2:0] cnt0, cnt1, cnt2;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc_now = 0;
  push_t pq[$];

  logic lg_tx   [3][MAXC];
  logic lg_busy [3][MAXC];
  logic lg_done [3][MAXC];
  logic e_tx    [MAXC];
  logic e_busy  [MAXC];
  logic e_done  [MAXC];

  uart_tx_fifo #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBits(8),
                 .ParityMode(0), .StopBits(1), .FifoDepth(4)) u_a (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data_v[0][7:0]), .wr_valid(wr_valid_v[0]),
    .wr_ready(rdy_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]),
    .fifo_count(cnt0));

  uart_tx_fifo #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBits(7),
                 .ParityMode(1), .StopBits(2), .FifoDepth(4)) u_e (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data_v[1][6:0]), .wr_valid(wr_valid_v[1]),
    .wr_ready(rdy_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]),
    .fifo_count(cnt1));

  uart_tx_fifo #(.ClockFreqHz(10000000), .BaudRate(1000000), .DataBits(7),
                 .ParityMode(2), .StopBits(2), .FifoDepth(4)) u_o (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data_v[2][6:0]), .wr_valid(wr_valid_v[2]),
    .wr_ready(rdy_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]),
    .fifo_count(cnt2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter plus per-cycle log, sampled 1 time unit after each edge.
  always @(posedge clk) begin
    cyc_now = cyc_now + 1;
    #1;
    if (cyc_now < MAXC) begin
      for (int s = 0; s < 3; s++) begin
        lg_tx[s][cyc_now]   = tx_w[s];
        lg_busy[s][cyc_now] = busy_w[s];
        lg_done[s][cyc_now] = done_w[s];
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int nbits(input int sel);
    return (sel == 0) ? 8 : 7;
  endfunction

  function automatic int frame_len(input int sel);
    return (1 + nbits(sel) + ((sel != 0) ? 1 : 0) + ((sel == 0) ? 1 : 2)) * BC;
  endfunction

  // Line level of bit slot idx of a frame carrying d (parity mode equals sel).
  function automatic logic fbit(input int sel, input logic [8:0] d, input int idx);
    int nb = nbits(sel);
    if (idx == 0) return 1'b0;
    if (idx <= nb) return d[idx-1];
    if (sel != 0 && idx == nb + 1) return (($countones(d) % 2) == 1) ^ (sel == 2);
    return 1'b1;
  endfunction

  // Drive one word; waits (bounded) for ready, returns the push edge number.
  task automatic push(input int sel, input logic [8:0] din, output int p);
    int waited = 0;
    logic [8:0] d;
    d = (sel == 0) ? (din & 9'h0FF) : (din & 9'h07F);
    wr_data_v[sel]  = d;
    wr_valid_v[sel] = 1'b1;
    while (rdy_w[sel] !== 1'b1 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    chk($sformatf("push_ready_d%0d", sel), {31'd0, rdy_w[sel]}, 32'd1);
    p = -1;
    if (rdy_w[sel] === 1'b1) begin
      @(posedge clk); #1;
      p = cyc_now;
      pq.push_back('{sel, p, d});
    end
    wr_valid_v[sel] = 1'b0;
    wr_data_v[sel]  = 9'($urandom);
  endtask

  task automatic wait_until(input int n);
    while (cyc_now < n) begin
      @(posedge clk); #1;
    end
  endtask

  // Expected waveform: each frame starts at max(push+1, previous frame end).
  task automatic verify(input int sel, input int w0, input int w1_in);
    int w1, len, pe, st;
    w1  = (w1_in < MAXC) ? w1_in : MAXC - 1;
    len = frame_len(sel);
    pe  = -1;
    for (int i = w0; i <= w1; i++) begin
      e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_done[i] = 1'b0;
    end
    foreach (pq[k]) begin
      if (pq[k].sel == sel && pq[k].p >= w0 && pq[k].p <= w1) begin
        st = (pq[k].p + 1 > pe) ? pq[k].p + 1 : pe;
        for (int c = 0; c < len; c++) begin
          if (st + c <= w1) begin
            e_tx[st+c]   = fbit(sel, pq[k].d, c / BC);
            e_busy[st+c] = 1'b1;
          end
        end
        if (st + len <= w1) e_done[st+len] = 1'b1;
        pe = st + len;
      end
    end
    for (int i = w0; i <= w1; i++) begin
      chk($sformatf("d%0d_tx@%0d", sel, i), {31'd0, lg_tx[sel][i]}, {31'd0, e_tx[i]});
      chk($sformatf("d%0d_busy@%0d", sel, i), {31'd0, lg_busy[sel][i]}, {31'd0, e_busy[i]});
      chk($sformatf("d%0d_done@%0d", sel, i), {31'd0, lg_done[sel][i]}, {31'd0, e_done[i]});
    end
  endtask

  initial begin
    int w0, p, p1, p4, p6, pb, pc;
    rst_n      = 1'b0;
    wr_valid_v = '0;
    for (int s = 0; s < 3; s++) wr_data_v[s] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rst_tx_d%0d", s),   {31'd0, tx_w[s]},   32'd1);
      chk($sformatf("rst_busy_d%0d", s), {31'd0, busy_w[s]}, 32'd0);
      chk($sformatf("rst_rdy_d%0d", s),  {31'd0, rdy_w[s]},  32'd0);
      chk($sformatf("rst_done_d%0d", s), {31'd0, done_w[s]}, 32'd0);
    end
    chk("rst_cnt_d0", {29'd0, cnt0}, 32'd0);
    chk("rst_cnt_d1", {29'd0, cnt1}, 32'd0);
    chk("rst_cnt_d2", {29'd0, cnt2}, 32'd0);
    #2 rst_n = 1'b1;
    #1 chk("rdy_before_first_edge", {31'd0, rdy_w[0]}, 32'd0);
    @(posedge clk); #1;
    for (int s = 0; s < 3; s++) chk($sformatf("rdy_after_release_d%0d", s), {31'd0, rdy_w[s]}, 32'd1);

    // 8N1 single word 0xA5
    w0 = cyc_now;
    push(0, 9'h0A5, p);
    wait_until(p + 1 + 100 + 5);
    chk("a5_bit0", {31'd0, lg_tx[0][p+1+15]}, 32'd1);
    chk("a5_bit1", {31'd0, lg_tx[0][p+1+25]}, 32'd0);
    chk("a5_done_at_100", {31'd0, lg_done[0][p+1+100]}, 32'd1);
    verify(0, w0, cyc_now - 1);

    // 7E2 with 0x55 and 7O2 with 0x00, then a few random words on each
    w0 = cyc_now;
    push(1, 9'h055, pb);
    push(2, 9'h000, pc);
    wait_until(pc + 1 + 110 + 5);
    chk("even_parity_55", {31'd0, lg_tx[1][pb+1+85]}, 32'd0);
    chk("odd_parity_00",  {31'd0, lg_tx[2][pc+1+85]}, 32'd1);
    chk("even_len_110",   {31'd0, lg_done[1][pb+1+110]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      push(1, 9'($urandom), p);
      push(2, 9'($urandom), p);
    end
    wait_until(p + 360);
    verify(1, w0, cyc_now - 1);
    verify(2, w0, cyc_now - 1);

    // Fill the FIFO with 0x01..0x06 while holding wr_valid
    w0 = cyc_now;
    push(0, 9'h001, p1);
    chk("fill_cnt_first", {29'd0, cnt0}, 32'd1);
    push(0, 9'h002, p);
    push(0, 9'h003, p);
    push(0, 9'h004, p);
    push(0, 9'h005, p);
    chk("fill_cnt_full", {29'd0, cnt0}, 32'd4);
    chk("fill_rdy_low",  {31'd0, rdy_w[0]}, 32'd0);
    push(0, 9'h006, p6);
    chk("fill_w6_edge", p6, p1 + 102);
    chk("fill_cnt_after_w6", {29'd0, cnt0}, 32'd4);
    wait_until(p1 + 1 + 600 + 5);
    verify(0, w0, cyc_now - 1);

    // Push on the same edge as a pop with two words queued
    w0 = cyc_now;
    push(0, 9'($urandom), p1);
    push(0, 9'($urandom), p);
    push(0, 9'($urandom), p);
    chk("pp_cnt_before", {29'd0, cnt0}, 32'd2);
    wait_until(p1 + 100);
    chk("pp_cnt_at_end", {29'd0, cnt0}, 32'd2);
    push(0, 9'($urandom), p4);
    chk("pp_push_edge", p4, p1 + 101);
    chk("pp_cnt_after", {29'd0, cnt0}, 32'd2);
    wait_until(p1 + 1 + 400 + 5);
    verify(0, w0, cyc_now - 1);

    // Reset in the middle of DATA with two words queued
    push(0, 9'($urandom), p1);
    push(0, 9'($urandom), p);
    push(0, 9'($urandom), p);
    wait_until(p1 + 1 + 35);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx",   {31'd0, tx_w[0]},   32'd1);
    chk("mid_rst_busy", {31'd0, busy_w[0]}, 32'd0);
    chk("mid_rst_cnt",  {29'd0, cnt0},      32'd0);
    chk("mid_rst_rdy",  {31'd0, rdy_w[0]},  32'd0);
    @(posedge clk); #1;
    chk("mid_rst_tx_held", {31'd0, tx_w[0]}, 32'd1);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_rdy", {31'd0, rdy_w[0]}, 32'd1);
    w0 = cyc_now;
    repeat (150) begin
      @(posedge clk); #1;
    end
    push(0, 9'($urandom), p);
    wait_until(p + 110);
    verify(0, w0, cyc_now - 1);

    // Random words with random gaps
    w0 = cyc_now;
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 120)) begin
        @(posedge clk); #1;
      end
      push(0, 9'($urandom), p);
    end
    wait_until(p + 520);
    verify(0, w0, cyc_now - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
